systolic_feeder: RTL and testbench
==================================

// Module: systolic_feeder
// PURPOSE
//  Operand staging and skew stage between controller and the 4x4 systolic array.
//  Holds matrices A and B, loaded during the controller's LOAD state.
//  On a rising edge of start_compute it streams A rows into the west edge and
//  B columns into the north edge, each diagonally skewed.
//  It then waits out array latency and pulses systolic_array_done back to controller.
// PARAMETERS
//  N   4  array dimension (rows = cols = N)
//  DW  8  operand width, unsigned
// PORTS
//  clk                  in   1     clock; all logic on posedge
//  rst                  in   1     asynchronous, active-low reset (0 = reset)
//  load_en              in   1     write one operand element this cycle
//  load_sel             in   1     0 = write A, 1 = write B
//  load_row             in   2     element row index (log2 N)
//  load_col             in   2     element column index (log2 N)
//  load_data            in   DW    element value
//  start_compute        in   1     level from controller, high throughout COMPUTE
//  a_out                out  N*DW  west-edge operands; slice i -> array row i
//  b_out                out  N*DW  north-edge operands; slice j -> array column j
//  acc_clear            out  1     one-cycle pulse: PEs zero accumulators
//  busy                 out  1     high from start edge through done cycle
//  systolic_array_done  out  1     one-cycle pulse to controller
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, start_q 0, counter 0, both banks cleared to 0.
//  - All outputs are registered.
//  - start edge = start_compute & ~start_q, where start_q is start_compute delayed one cycle.
//    The edge is acted on only in IDLE; level-high never retriggers.
//  - States: IDLE -> FEED -> DRAIN -> DONE -> IDLE.
//  - Cycle numbering: cycle 0 is the cycle after the posedge that samples the edge.
//  - IDLE -> FEED on start edge.
//    Cycle 0: acc_clear=1, busy=1, a_out/b_out = 0.
//  - FEED, cycles 1+t for t = 0..2N-2 (counter t):
//    a_out[i] = A[i][t-i] if 0 <= t-i < N, else 0.
//    b_out[j] = B[t-j][j] if 0 <= t-j < N, else 0.
//  - DRAIN, cycles 2N..3N-2 (N-1 cycles): a_out = b_out = 0.
//  - DONE, cycle 3N-1: systolic_array_done=1 and busy=1; then IDLE with busy=0.
//  - For N=4: data on cycles 1..7, drain on cycles 8..10, done on cycle 11.
//  - Start edge to done pulse = 3N-1 cycles.
//  - Loads: a write lands at the next posedge and only when state is IDLE.
//    load_en outside IDLE is dropped silently.
//  - Load and start edge in the same IDLE cycle: the write lands.
//    FEED reads the updated value.
//  - start_compute falling mid-operation: ignored; the sequence completes.
//  - Re-issue (controller DONE -> COMPUTE): requires start_compute low for at
//    least one cycle, then a new edge in IDLE. The banks are reused unchanged.
//  - Reset mid-operation: immediately IDLE, outputs 0, banks cleared,
//    no done pulse.
//  - Counter width is $clog2(3N) bits; no wrap, because it saturates via state exit.
// STRUCTURE
//  - systolic_pkg holds:
//    - SA_N, SA_DW;
//    - feeder_state_t enum {IDLE, FEED, DRAIN, DONE};
//    - localparams FEED_LEN = 2*SA_N-1 and DRAIN_LEN = SA_N-1.
//  - Sub-module operand_bank (N x N x DW registers; one write port; read of
//    element [r][c] by index) is instantiated twice, for A and B.
//  - Skew muxing, FSM and counter live in systolic_feeder.
// TESTING
//  1. A = identity, B[r][c] = 4r+c+1, start edge.
//     -> cycle 0 acc_clear=1;
//     -> cycle 1 a_out = {0,0,0,1}, b_out = {0,0,0,1};
//     -> cycle 4 a_out[3] = 0 and b_out[3] = B[0][3] = 4;
//     -> cycle 7 a_out[3] = 1 and b_out[3] = 16;
//     -> cycles 8..10 all zero.
//  2. Same run -> systolic_array_done high only on cycle 11; busy high on cycles 0..11.
//  3. Hold start_compute high 30 cycles -> exactly one done pulse.
//     Drop start_compute for 1 cycle, raise again -> second identical sequence.
//  4. load_en with data 8'hFF to A[0][0] during FEED -> ignored.
//     Next run a_out[0] on cycle 1 equals the original A[0][0].
//  5. Drive rst=0 on cycle 5 -> outputs 0 asynchronously and no done pulse.
//     After release, a new edge restarts with all-zero banks.
//  6. Write B[3][3]=8'h2A in the same cycle as the start edge -> b_out[3] = 8'h2A on cycle 7.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Purpose : shared sizes, FSM encoding and phase lengths for the systolic operand feeder.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

    localparam int SA_N  = 4;   // array dimension (rows = cols)
    localparam int SA_DW = 8;   // operand width, unsigned

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // Skewed streaming of an N x N tile occupies 2N-1 data cycles;
    // the last operand then needs N-1 more cycles to cross the array.
    localparam int FEED_LEN  = 2 * SA_N - 1;
    localparam int DRAIN_LEN = SA_N - 1;

endpackage

// File: rtl/systolic_feeder_if.sv
// Purpose : controller <-> feeder bundle: element loads, compute level, skewed operands, status.
// Latency : n/a (wiring only).
// Backpressure: none; loads are accepted only while the feeder is idle, otherwise dropped.
// Ports   : master = controller side (drives load_*/start_compute),
//           slave  = feeder side (drives a_out/b_out/acc_clear/busy/systolic_array_done).
interface systolic_feeder_if;
    import systolic_pkg::*;

    logic                        load_en;
    logic                        load_sel;       // 0 = A bank, 1 = B bank
    logic [$clog2(SA_N)-1:0]     load_row;
    logic [$clog2(SA_N)-1:0]     load_col;
    logic [SA_DW-1:0]            load_data;
    logic                        start_compute;  // level, high throughout COMPUTE
    logic [SA_N*SA_DW-1:0]       a_out;          // slice i -> array row i (west edge)
    logic [SA_N*SA_DW-1:0]       b_out;          // slice j -> array column j (north edge)
    logic                        acc_clear;
    logic                        busy;
    logic                        systolic_array_done;

    modport master (
        output load_en, load_sel, load_row, load_col, load_data, start_compute,
        input  a_out, b_out, acc_clear, busy, systolic_array_done
    );

    modport slave (
        input  load_en, load_sel, load_row, load_col, load_data, start_compute,
        output a_out, b_out, acc_clear, busy, systolic_array_done
    );

endinterface

// File: rtl/systolic_feeder_operand_bank.sv
// Purpose : N x N x DW operand register file, one write port, N independent combinational read ports.
// Latency : write visible one cycle after the write posedge; reads are combinational.
// Backpressure: none; a write with we=1 always lands.
// Ports   : clk/rst (async active-low), we/wr_row/wr_col/wr_data write port,
//           rd_row[k]/rd_col[k] -> rd_data[k] for k = 0..N-1.
module operand_bank
    import systolic_pkg::*;
#(
    parameter int N  = SA_N,
    parameter int DW = SA_DW,
    parameter int RW = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [RW-1:0]              wr_row,
    input  logic [RW-1:0]              wr_col,
    input  logic [DW-1:0]              wr_data,
    input  logic [N-1:0][RW-1:0]       rd_row,
    input  logic [N-1:0][RW-1:0]       rd_col,
    output logic [N-1:0][DW-1:0]       rd_data
);

    logic [N-1:0][N-1:0][DW-1:0] mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (we) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N; k++) begin
            rd_data[k] = mem[rd_row[k]][rd_col[k]];
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Purpose : stage A/B operands and stream them diagonally skewed into a 4x4 systolic array,
//           then wait out array latency and pulse done back to the controller.
// Latency : start edge -> acc_clear next cycle (cycle 0), data cycles 1..2N-1, done on cycle 3N-1.
// Backpressure: none; loads outside IDLE are dropped, start level-high never retriggers.
// Ports   : clk, rst (async active-low), bus (systolic_feeder_if.slave).
module systolic_feeder
    import systolic_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    systolic_feeder_if.slave   bus
);

    localparam int CW = $clog2(3 * SA_N);
    localparam int RW = $clog2(SA_N);

    feeder_state_t              state;
    logic [CW-1:0]              cnt;
    logic                       start_q;
    logic                       start_edge;

    logic [SA_N*SA_DW-1:0]      a_q;
    logic [SA_N*SA_DW-1:0]      b_q;
    logic                       acc_clear_q;
    logic                       busy_q;
    logic                       done_q;

    logic                       a_we;
    logic                       b_we;
    logic [SA_N-1:0][RW-1:0]    a_rd_row;
    logic [SA_N-1:0][RW-1:0]    a_rd_col;
    logic [SA_N-1:0][RW-1:0]    b_rd_row;
    logic [SA_N-1:0][RW-1:0]    b_rd_col;
    logic [SA_N-1:0][SA_DW-1:0] a_rd;
    logic [SA_N-1:0][SA_DW-1:0] b_rd;

    logic [SA_N-1:0][CW-1:0]    diag;      // cnt - lane: position of this lane inside its skewed window
    logic [SA_N-1:0]            lane_vld;
    logic [SA_N*SA_DW-1:0]      feed_a;
    logic [SA_N*SA_DW-1:0]      feed_b;

    assign start_edge = bus.start_compute & ~start_q;

    // Banks only accept writes while idle so an in-flight stream never sees a torn tile.
    assign a_we = bus.load_en && (state == IDLE) && !bus.load_sel;
    assign b_we = bus.load_en && (state == IDLE) &&  bus.load_sel;

    operand_bank #(.N(SA_N), .DW(SA_DW), .RW(RW)) u_bank_a (
        .clk     (clk),
        .rst     (rst),
        .we      (a_we),
        .wr_row  (bus.load_row),
        .wr_col  (bus.load_col),
        .wr_data (bus.load_data),
        .rd_row  (a_rd_row),
        .rd_col  (a_rd_col),
        .rd_data (a_rd)
    );

    operand_bank #(.N(SA_N), .DW(SA_DW), .RW(RW)) u_bank_b (
        .clk     (clk),
        .rst     (rst),
        .we      (b_we),
        .wr_row  (bus.load_row),
        .wr_col  (bus.load_col),
        .wr_data (bus.load_data),
        .rd_row  (b_rd_row),
        .rd_col  (b_rd_col),
        .rd_data (b_rd)
    );

    // Diagonal skew: lane k is delayed by k cycles, so at step t it carries
    // A[k][t-k] (west) and B[t-k][k] (north) while 0 <= t-k < N.
    always_comb begin
        diag     = '0;
        lane_vld = '0;
        a_rd_row = '0;
        a_rd_col = '0;
        b_rd_row = '0;
        b_rd_col = '0;
        feed_a   = '0;
        feed_b   = '0;
        for (int k = 0; k < SA_N; k++) begin
            diag[k]     = cnt - CW'(k);
            lane_vld[k] = (cnt >= CW'(k)) && (diag[k] < CW'(SA_N));
            a_rd_row[k] = RW'(k);
            a_rd_col[k] = diag[k][RW-1:0];
            b_rd_row[k] = diag[k][RW-1:0];
            b_rd_col[k] = RW'(k);
            feed_a[k*SA_DW +: SA_DW] = lane_vld[k] ? a_rd[k] : '0;
            feed_b[k*SA_DW +: SA_DW] = lane_vld[k] ? b_rd[k] : '0;
        end
    end

    // All outputs are registered. The state register runs one cycle ahead of the
    // output it produces: the FEED step with cnt=t loads the registers shown on cycle 1+t,
    // and the DONE state loads the done pulse shown on cycle 3N-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            start_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            start_q     <= bus.start_compute;
            acc_clear_q <= 1'b0;
            done_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state       <= FEED;
                        cnt         <= '0;
                        acc_clear_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        busy_q      <= 1'b0;
                    end
                end
                FEED: begin
                    a_q    <= feed_a;
                    b_q    <= feed_b;
                    busy_q <= 1'b1;
                    if (cnt == CW'(FEED_LEN - 1)) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    busy_q <= 1'b1;
                    if (cnt == CW'(DRAIN_LEN - 1)) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b1;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_out               = a_q;
    assign bus.b_out               = b_q;
    assign bus.acc_clear           = acc_clear_q;
    assign bus.busy                = busy_q;
    assign bus.systolic_array_done = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Purpose : directed scoreboard bench for systolic_feeder: skew pattern, timing, retrigger, load gating, reset.
// Latency : expected per-cycle records are queued at each start edge and popped one per cycle.
// Backpressure: n/a.
module tb_systolic_feeder;

    localparam int N        = 4;
    localparam int DW       = 8;
    localparam int DONE_CYC = 3 * N - 1;

    typedef struct {
        logic [N*DW-1:0] a;
        logic [N*DW-1:0] b;
        logic            clr;
        logic            busy;
        logic            done;
        int              cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   run_id;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];
    exp_t          sb [$];

    systolic_feeder_if bus ();

    systolic_feeder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic cmp(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t expect_cycle(input int k);
        exp_t e;
        int   t;
        e.cyc  = k;
        e.clr  = (k == 0);
        e.busy = (k <= DONE_CYC);
        e.done = (k == DONE_CYC);
        e.a    = '0;
        e.b    = '0;
        if (k >= 1 && k <= 2 * N - 1) begin
            t = k - 1;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    e.a[i*DW +: DW] = ma[i][t-i];
                    e.b[i*DW +: DW] = mb[t-i][i];
                end
            end
        end
        return e;
    endfunction

    // One full sequence plus the first idle cycle after it.
    task automatic push_run();
        run_id++;
        for (int k = 0; k <= DONE_CYC + 1; k++) sb.push_back(expect_cycle(k));
    endtask

    task automatic check_cycle();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty run%0d observed=0 expected=1", run_id);
        end else begin
            e = sb.pop_front();
            cmp($sformatf("run%0d_c%0d_a", run_id, e.cyc), bus.a_out, e.a);
            cmp($sformatf("run%0d_c%0d_b", run_id, e.cyc), bus.b_out, e.b);
            cmp($sformatf("run%0d_c%0d_clr", run_id, e.cyc), {31'd0, bus.acc_clear}, {31'd0, e.clr});
            cmp($sformatf("run%0d_c%0d_busy", run_id, e.cyc), {31'd0, bus.busy}, {31'd0, e.busy});
            cmp($sformatf("run%0d_c%0d_done", run_id, e.cyc), {31'd0, bus.systolic_array_done}, {31'd0, e.done});
        end
    endtask

    task automatic check_quiet(input string tag);
        cmp({tag, "_a"}, bus.a_out, '0);
        cmp({tag, "_b"}, bus.b_out, '0);
        cmp({tag, "_clr"}, {31'd0, bus.acc_clear}, 32'd0);
        cmp({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        cmp({tag, "_done"}, {31'd0, bus.systolic_array_done}, 32'd0);
    endtask

    task automatic do_load(input logic sel, input int r, input int c, input logic [DW-1:0] d);
        bus.load_en   = 1'b1;
        bus.load_sel  = sel;
        bus.load_row  = 2'(r);
        bus.load_col  = 2'(c);
        bus.load_data = d;
        @(negedge clk);
        bus.load_en   = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        run_id = 0;
        rst                = 1'b0;
        bus.load_en        = 1'b0;
        bus.load_sel       = 1'b0;
        bus.load_row       = '0;
        bus.load_col       = '0;
        bus.load_data      = '0;
        bus.start_compute  = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end

        // Reset state
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        // A = identity, B[r][c] = 4r+c+1
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = (r == c) ? 8'd1 : 8'd0;
                mb[r][c] = 8'(4 * r + c + 1);
                do_load(1'b0, r, c, ma[r][c]);
                do_load(1'b1, r, c, mb[r][c]);
            end

        // Run 1: skew pattern and timing
        bus.start_compute = 1'b1;
        push_run();
        for (int k = 0; k <= DONE_CYC + 1; k++) check_cycle();

        // Level held high must not retrigger
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            cmp($sformatf("hold_c%0d_done", k), {31'd0, bus.systolic_array_done}, 32'd0);
            cmp($sformatf("hold_c%0d_busy", k), {31'd0, bus.busy}, 32'd0);
        end

        // Run 2: re-issue after one low cycle; a load during FEED is dropped
        bus.start_compute = 1'b0;
        @(negedge clk);
        bus.start_compute = 1'b1;
        push_run();
        for (int k = 0; k <= DONE_CYC + 1; k++) begin
            check_cycle();
            if (k == 2) begin
                bus.load_en   = 1'b1;
                bus.load_sel  = 1'b0;
                bus.load_row  = 2'd0;
                bus.load_col  = 2'd0;
                bus.load_data = 8'hFF;
            end
            if (k == 3) bus.load_en = 1'b0;
        end

        // Run 3: B[3][3] written in the same cycle as the start edge; A[0][0] still original
        bus.start_compute = 1'b0;
        @(negedge clk);
        bus.start_compute = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_sel  = 1'b1;
        bus.load_row  = 2'd3;
        bus.load_col  = 2'd3;
        bus.load_data = 8'h2A;
        mb[3][3] = 8'h2A;
        push_run();
        for (int k = 0; k <= DONE_CYC + 1; k++) begin
            check_cycle();
            if (k == 0) bus.load_en = 1'b0;
        end

        // Run 4: reset asserted on cycle 5
        bus.start_compute = 1'b0;
        @(negedge clk);
        bus.start_compute = 1'b1;
        push_run();
        for (int k = 0; k < 5; k++) check_cycle();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_quiet("async_reset");
        sb.delete();
        bus.start_compute = 1'b0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            cmp($sformatf("after_reset_c%0d_done", k), {31'd0, bus.systolic_array_done}, 32'd0);
        end

        // Run 5: restart sees all-zero banks
        bus.start_compute = 1'b1;
        push_run();
        for (int k = 0; k <= DONE_CYC + 1; k++) check_cycle();
        bus.start_compute = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
